// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receiver.
//
// This block generates the programmable 16x oversampling tick that paces the
// receiver. It captures each completed frame, together with its parity and
// frame error flags, into a first-word fall-through FIFO. The FIFO is
// presented to the consumer as a valid/ready stream. The block also keeps
// sticky overrun status and a saturating error counter for software.
//
// Stream handshake: m_valid is high whenever the FIFO holds at least one
// entry. m_data/m_err always show the head entry while m_valid is high. An
// entry is consumed in any cycle where m_valid & m_ready are both high at the
// rising clock edge. m_ready is ignored while m_valid is low.
//
// Ports:
//   clk, reset     system clock; synchronous active-high reset
//   enable         receive path active (tick running, frames accepted)
//   baud_div       clk cycles per tick_16x, minus 1
//   tick_16x       one-cycle oversampling strobe to the receiver
//   rx_data        received word, valid while data_ready is high
//   data_ready     one-cycle frame-complete pulse
//   parity_err     parity error flag of the current frame
//   frame_err      stop-bit error flag of the current frame
//   m_data, m_err  FIFO head word and flags {parity_err, frame_err}
//   m_valid        FIFO non-empty
//   m_ready        consumer accepts the head entry
//   fifo_count     occupancy, 0..FIFO_DEPTH
//   overrun        sticky: a frame was dropped on a full FIFO
//   err_count      saturating count of accepted frames with an error flag
//   clear_status   clears overrun and err_count
module uart_rx_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [DIV_WIDTH-1:0]          baud_div,
   output logic                          tick_16x,
   input  logic [DATA_BITS-1:0]          rx_data,
   input  logic                          data_ready,
   input  logic                          parity_err,
   input  logic                          frame_err,
   output logic [DATA_BITS-1:0]          m_data,
   output logic [1:0]                    m_err,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic [7:0]                    err_count,
   input  logic                          clear_status
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = DATA_BITS + 2;

   // ---------------------------------------------------------------
   // Tick generator
   // ---------------------------------------------------------------
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
   logic                 tick_q, tick_d;

   always_comb begin
      div_cnt_d = '0;
      tick_d    = 1'b0;
      if (enable) begin
         // The >= compare ensures the counter wraps on the next cycle
         // if baud_div is lowered below the current count.
         if (div_cnt_q >= baud_div) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         tick_q    <= tick_d;
      end
   end

   assign tick_16x = tick_q;

   // ---------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overrun_q, overrun_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   logic push, pop, full, accept, drop, frame_has_err;

   assign push          = data_ready & enable;
   assign full          = (count_q == CW'(FIFO_DEPTH));
   assign pop           = m_valid & m_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign accept        = push & (~full | pop);
   assign drop          = push & full & ~pop;
   assign frame_has_err = parity_err | frame_err;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (pop && !accept) count_d = count_q - 1'b1;
   end

   // Status: an event in the same cycle as clear_status takes precedence.
   always_comb begin
      overrun_d = overrun_q;
      err_cnt_d = err_cnt_q;
      if (drop)              overrun_d = 1'b1;
      else if (clear_status) overrun_d = 1'b0;

      if (clear_status) begin
         err_cnt_d = (accept && frame_has_err) ? 8'd1 : 8'd0;
      end else if (accept && frame_has_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         mem_q[wr_ptr_q] <= {parity_err, frame_err, rx_data};
      end
   end

   logic [EW-1:0] head;
   assign head = mem_q[rd_ptr_q];

   assign m_valid    = (count_q != '0);
   // Head is forced to zero when empty so the outputs are defined after reset.
   assign m_data     = m_valid ? head[DATA_BITS-1:0] : '0;
   assign m_err      = m_valid ? head[EW-1:DATA_BITS] : 2'b00;
   assign fifo_count = count_q;
   assign overrun    = overrun_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

   localparam int DB    = 8;
   localparam int DEPTH = 8;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          reset, enable, data_ready, parity_err, frame_err;
   logic          m_ready, clear_status;
   logic [DW-1:0] baud_div;
   logic [DB-1:0] rx_data;
   logic          tick_16x, m_valid, overrun;
   logic [DB-1:0] m_data;
   logic [1:0]    m_err;
   logic [3:0]    fifo_count;
   logic [7:0]    err_count;

   uart_rx_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .baud_div(baud_div),
      .tick_16x(tick_16x), .rx_data(rx_data), .data_ready(data_ready),
      .parity_err(parity_err), .frame_err(frame_err), .m_data(m_data),
      .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
      .fifo_count(fifo_count), .overrun(overrun), .err_count(err_count),
      .clear_status(clear_status)
   );

   always #5 clk = ~clk;

   // Reference model state
   int            checks = 0;
   int            errors = 0;
   logic [DB+1:0] exp_q[$];
   int            exp_ovr, exp_ec, en_cycles;
   logic          exp_tick;
   logic [DB+1:0] last_pop;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using current inputs, clock the DUT,
   // then compare every observable output against the model.
   task automatic cycle();
      bit push, pop, acc, drop, errf;
      if (reset) begin
         exp_q.delete();
         exp_ovr   = 0;
         exp_ec    = 0;
         en_cycles = 0;
         exp_tick  = 1'b0;
      end else begin
         push = data_ready && enable;
         pop  = (exp_q.size() > 0) && m_ready;
         acc  = push && ((exp_q.size() < DEPTH) || pop);
         drop = push && !acc;
         errf = acc && (parity_err || frame_err);
         if (pop) last_pop = exp_q.pop_front();
         if (acc) exp_q.push_back({parity_err, frame_err, rx_data});
         if (drop) exp_ovr = 1;
         else if (clear_status) exp_ovr = 0;
         if (clear_status) exp_ec = errf ? 1 : 0;
         else if (errf && exp_ec < 255) exp_ec++;
         // Tick every (baud_div+1)-th cycle counted from when enable rose.
         if (enable) begin
            en_cycles++;
            exp_tick = ((en_cycles % (int'(baud_div) + 1)) == 0);
         end else begin
            en_cycles = 0;
            exp_tick  = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("tick", 32'(tick_16x), 32'(exp_tick));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
      chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("err_count", 32'(err_count), 32'(exp_ec));
      if (exp_q.size() > 0) begin
         chk("m_data", 32'(m_data), 32'(exp_q[0][DB-1:0]));
         chk("m_err", 32'(m_err), 32'(exp_q[0][DB+1:DB]));
      end
   endtask

   task automatic push_frame(input logic [DB-1:0] d, input logic pe, input logic fe);
      data_ready = 1'b1;
      rx_data    = d;
      parity_err = pe;
      frame_err  = fe;
      cycle();
      data_ready = 1'b0;
      parity_err = 1'b0;
      frame_err  = 1'b0;
   endtask

   initial begin
      int n_tick, first_tick, last_val;
      reset = 1'b1; enable = 1'b0; baud_div = 16'd3; rx_data = '0;
      data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
      m_ready = 1'b0; clear_status = 1'b0;
      en_cycles = 0; exp_ovr = 0; exp_ec = 0; exp_tick = 1'b0; last_pop = '0;

      // Reset state
      cycle();
      cycle();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_err", 32'(m_err), 32'd0);
      chk("rst_tick", 32'(tick_16x), 32'd0);
      reset = 1'b0;

      // Tick generator: period 4 with baud_div=3
      enable = 1'b1;
      n_tick = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (tick_16x) n_tick++;
      end
      chk("tick_count_12", 32'(n_tick), 32'd3);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      enable = 1'b1;
      first_tick = -1;
      for (int i = 1; i <= 4; i++) begin
         cycle();
         if (tick_16x && first_tick < 0) first_tick = i;
      end
      chk("tick_restart", 32'(first_tick), 32'd4);

      // Single push then pop
      push_frame(8'hA5, 1'b0, 1'b0);
      chk("a5_valid", 32'(m_valid), 32'd1);
      chk("a5_data", 32'(m_data), 32'hA5);
      chk("a5_err", 32'(m_err), 32'd0);
      chk("a5_count", 32'(fifo_count), 32'd1);
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      chk("a5_popped_valid", 32'(m_valid), 32'd0);
      chk("a5_popped_count", 32'(fifo_count), 32'd0);

      // Overflow: 9 frames into 8 entries
      for (int i = 1; i <= 9; i++) push_frame(DB'(i), 1'b0, 1'b0);
      chk("ovf_count", 32'(fifo_count), 32'd8);
      chk("ovf_overrun", 32'(overrun), 32'd1);
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("ovf_drain", 32'(m_data), 32'(i));
         cycle();
      end
      m_ready = 1'b0;
      chk("ovf_empty", 32'(m_valid), 32'd0);

      // Push and pop together while full
      clear_status = 1'b1;
      cycle();
      clear_status = 1'b0;
      chk("clr_overrun", 32'(overrun), 32'd0);
      for (int i = 1; i <= 8; i++) push_frame(DB'(32'h20 + i), 1'b0, 1'b0);
      m_ready = 1'b1;
      push_frame(8'h10, 1'b0, 1'b0);
      chk("fullpp_count", 32'(fifo_count), 32'd8);
      chk("fullpp_overrun", 32'(overrun), 32'd0);
      chk("fullpp_head", 32'(m_data), 32'h22);
      last_val = 0;
      for (int i = 0; i < 8; i++) begin
         last_val = int'(m_data);
         cycle();
      end
      m_ready = 1'b0;
      chk("fullpp_last", 32'(last_val), 32'h10);

      // Error flags and counter
      push_frame(8'h33, 1'b0, 1'b1);
      push_frame(8'h44, 1'b1, 1'b0);
      chk("err_first_data", 32'(m_data), 32'h33);
      chk("err_first_flags", 32'(m_err), 32'b01);
      chk("err_count_2", 32'(err_count), 32'd2);
      m_ready = 1'b1;
      cycle();
      chk("err_second_flags", 32'(m_err), 32'b10);
      cycle();
      m_ready = 1'b0;
      clear_status = 1'b1;
      push_frame(8'h55, 1'b0, 1'b1);
      clear_status = 1'b0;
      chk("err_clear_wins", 32'(err_count), 32'd1);
      m_ready = 1'b1;
      cycle();

      // Saturation with continuous drain
      for (int i = 0; i < 300; i++) begin
         logic [1:0] e;
         e = 2'($urandom_range(1, 3));
         push_frame(DB'($urandom), e[1], e[0]);
      end
      chk("err_saturate", 32'(err_count), 32'd255);
      cycle();
      cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         enable       = ($urandom_range(0, 9) != 0);
         data_ready   = $urandom_range(0, 1) == 1;
         rx_data      = DB'($urandom);
         parity_err   = $urandom_range(0, 3) == 0;
         frame_err    = $urandom_range(0, 3) == 0;
         m_ready      = $urandom_range(0, 2) == 0;
         clear_status = $urandom_range(0, 19) == 0;
         cycle();
      end
      data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
      clear_status = 1'b0; enable = 1'b1;

      // Reset with three queued entries
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_frame(DB'(32'h60 + i), 1'b1, 1'b0);
      chk("pre_rst_count", 32'(fifo_count), 32'd3);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst3_valid", 32'(m_valid), 32'd0);
      chk("rst3_count", 32'(fifo_count), 32'd0);
      chk("rst3_err_count", 32'(err_count), 32'd0);

      // baud_div=0: tick every cycle
      enable = 1'b0;
      cycle();
      baud_div = '0;
      enable = 1'b1;
      n_tick = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (tick_16x) n_tick++;
      end
      chk("tick_div0", 32'(n_tick), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
